dsp_mem_stage: RTL

- Parametrised memory-access stage of the DSP datapath, sitting between execute/decode and the register-file write port.
- Executes NONE / LD / ST / LD_IMM operations against NUM_BANKS synchronous SRAM banks.
- Bank is selected from upper address bits. Read latency is configurable.
- All write-back results are returned in order through a credit-controlled output FIFO with valid/ready backpressure.

---
 rtl/dsp_mem_stage.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/dsp_mem_stage.sv
// Memory-access stage: issues LD/ST to banked SRAM, returns in-order
// write-back results through a credit-controlled output FIFO.
module dsp_mem_stage #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned NUM_BANKS = 2,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned REG_AW    = 4,
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2:0]                  mem_mode,
    input  logic [DATA_W-1:0]           data_s1,
    input  logic [DATA_W-1:0]           data_s2,
    input  logic [DATA_W-1:0]           alu_result,
    input  logic                        wb_en,
    input  logic [REG_AW-1:0]           wb_rd_in,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [NUM_BANKS-1:0]        mem_re,
    output logic [NUM_BANKS-1:0]        mem_we,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [NUM_BANKS*DATA_W-1:0] mem_rdata,
    output logic                        wb_valid,
    input  logic                        wb_ready,
    output logic [REG_AW-1:0]           wb_rd,
    output logic [DATA_W-1:0]           wb_data,
    output logic                        err
);

    localparam int unsigned BSEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned BW1    = BSEL_W + 1;
    localparam int unsigned PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(OUT_DEPTH + RD_LAT + 2);
    localparam int unsigned LAST   = RD_LAT - 1;

    typedef enum logic [2:0] {
        MODE_NONE   = 3'd0,
        MODE_LD     = 3'd1,
        MODE_ST     = 3'd2,
        MODE_LD_IMM = 3'd3
    } mode_e;

    logic              accept_c, bank_ok_c, is_ld_c, is_st_c, needs_wb_c, err_set_c;
    logic [BSEL_W-1:0] bank_field_c, bank_idx_c;
    logic [DATA_W-1:0] imm_c, rdata_sel_c;
    logic              push, pop;
    logic              unused_c;

    logic              pipe_v    [RD_LAT];
    logic              pipe_ld   [RD_LAT];
    logic              pipe_ok   [RD_LAT];
    logic [BSEL_W-1:0] pipe_bank [RD_LAT];
    logic [REG_AW-1:0] pipe_rd   [RD_LAT];
    logic [DATA_W-1:0] pipe_val  [RD_LAT];

    logic              res_v_q;
    logic [REG_AW-1:0] res_rd_q;
    logic [DATA_W-1:0] res_data_q;

    logic [DATA_W-1:0] fifo_data_q [OUT_DEPTH];
    logic [REG_AW-1:0] fifo_rd_q   [OUT_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  fifo_count_q, inflight_q;
    logic              err_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Operation decode, credit check and SRAM strobes for the accepted op
    always_comb begin
        bank_field_c = data_s1[ADDR_W +: BSEL_W];
        bank_idx_c   = (NUM_BANKS == 1) ? '0 : bank_field_c;
        bank_ok_c    = (NUM_BANKS == 1) || ({1'b0, bank_field_c} < BW1'(NUM_BANKS));
        in_ready     = !rst && ((fifo_count_q + inflight_q) < CNT_W'(OUT_DEPTH));
        accept_c     = in_valid && in_ready;
        is_ld_c      = accept_c && (mem_mode == MODE_LD);
        is_st_c      = accept_c && (mem_mode == MODE_ST);
        needs_wb_c   = is_ld_c || (accept_c && ((mem_mode == MODE_LD_IMM) ||
                                                 ((mem_mode == MODE_NONE) && wb_en)));
        imm_c        = (mem_mode == MODE_LD_IMM) ? data_s2 : alu_result;
        err_set_c    = accept_c && ((mem_mode > MODE_LD_IMM) ||
                                    ((is_ld_c || is_st_c) && !bank_ok_c));
        mem_addr     = data_s1[ADDR_W-1:0];
        mem_wdata    = data_s2;
        mem_re       = (is_ld_c && bank_ok_c) ? (NUM_BANKS'(1) << bank_idx_c) : '0;
        mem_we       = (is_st_c && bank_ok_c) ? (NUM_BANKS'(1) << bank_idx_c) : '0;
        unused_c     = ^data_s1;
    end

    // Select the returning bank's read data for the oldest pipe entry
    always_comb begin
        rdata_sel_c = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (pipe_bank[LAST] == BSEL_W'(b)) rdata_sel_c = mem_rdata[b*DATA_W +: DATA_W];
        end
    end

    // RD_LAT-deep shift pipe carrying every write-back op so order is kept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_v[i]    <= 1'b0;
                pipe_ld[i]   <= 1'b0;
                pipe_ok[i]   <= 1'b0;
                pipe_bank[i] <= '0;
                pipe_rd[i]   <= '0;
                pipe_val[i]  <= '0;
            end
        end else begin
            pipe_v[0]    <= needs_wb_c;
            pipe_ld[0]   <= is_ld_c;
            pipe_ok[0]   <= bank_ok_c;
            pipe_bank[0] <= bank_idx_c;
            pipe_rd[0]   <= wb_rd_in;
            pipe_val[0]  <= imm_c;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_ld[i]   <= pipe_ld[i-1];
                pipe_ok[i]   <= pipe_ok[i-1];
                pipe_bank[i] <= pipe_bank[i-1];
                pipe_rd[i]   <= pipe_rd[i-1];
                pipe_val[i]  <= pipe_val[i-1];
            end
        end
    end

    // Capture stage: resolves load data (0 for an illegal bank) or the literal
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_v_q    <= 1'b0;
            res_rd_q   <= '0;
            res_data_q <= '0;
        end else begin
            res_v_q    <= pipe_v[LAST];
            res_rd_q   <= pipe_rd[LAST];
            res_data_q <= !pipe_ld[LAST] ? pipe_val[LAST] :
                          (pipe_ok[LAST] ? rdata_sel_c : '0);
        end
    end

    assign push     = res_v_q;
    assign pop      = wb_valid && wb_ready;
    assign wb_valid = (fifo_count_q != '0);
    assign wb_data  = fifo_data_q[rd_ptr_q];
    assign wb_rd    = fifo_rd_q[rd_ptr_q];
    assign err      = err_q;

    // Output FIFO, credit counter and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_rd_q[i]   <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            inflight_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= res_data_q;
                fifo_rd_q[wr_ptr_q]   <= res_rd_q;
                wr_ptr_q              <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   fifo_count_q <= fifo_count_q + CNT_W'(1);
                2'b01:   fifo_count_q <= fifo_count_q - CNT_W'(1);
                default: fifo_count_q <= fifo_count_q;
            endcase
            inflight_q <= inflight_q + CNT_W'(needs_wb_c) - CNT_W'(push);
            if (err_set_c) err_q <= 1'b1;
        end
    end

endmodule
